// File: rtl/run_stream_pkg.sv
// Shared types and defaults for the run stream transmitter.
// Imported by the transmitter top and its run monitor.
package run_stream_pkg;

  localparam int DETECT_N_DEF = 4;
  localparam int LEN_W_DEF    = 4;

  typedef enum logic {
    IDLE,
    SEND
  } tx_state_t;

endpackage

// File: rtl/run_stream_monitor.sv
// Run monitor: flags DETECT_N consecutive equal samples of s.
// Mirrors the downstream detector so run_flag lines up with it.
module run_monitor
  import run_stream_pkg::*;
#(
  parameter int DETECT_N = DETECT_N_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  output logic flag
);

  localparam int CW = $clog2(DETECT_N + 1);
  localparam logic [CW-1:0] CMAX = CW'(DETECT_N);
  localparam logic [CW-1:0] CONE = CW'(1);

  logic          hist_bit_q;
  logic          hist_valid_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Saturate at DETECT_N so a long hold never wraps the flag off.
  always_comb begin
    cnt_d = CONE;
    if (hist_valid_q && (s == hist_bit_q)) begin
      cnt_d = (cnt_q == CMAX) ? CMAX : cnt_q + CONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_bit_q   <= 1'b0;
      hist_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      hist_bit_q   <= s;
      hist_valid_q <= 1'b1;
      cnt_q        <= cnt_d;
    end
  end

  assign flag = (cnt_q == CMAX);

endmodule

// File: rtl/run_stream_tx.sv
// Serial run transmitter: expands (bit, len) commands onto w_out.
// Paced by bit_en, with back-to-back reload on the last bit.
module run_stream_tx
  import run_stream_pkg::*;
#(
  parameter int LEN_W    = LEN_W_DEF,
  parameter int DETECT_N = DETECT_N_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_bit,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             bit_en,
  output logic             w_out,
  output logic             w_strobe,
  output logic             busy,
  output logic             done,
  output logic             run_flag
);

  localparam logic [LEN_W-1:0] REM_ONE = LEN_W'(1);

  tx_state_t        state_q;
  logic [LEN_W-1:0] rem_q;
  logic             cur_bit_q;
  logic             w_out_q;
  logic             w_strobe_q;
  logic             done_q;

  logic last;
  logic accept;
  logic load;

  assign last      = (state_q == SEND) & bit_en & (rem_q == REM_ONE);
  assign cmd_ready = (state_q == IDLE) | last;
  assign accept    = cmd_valid & cmd_ready;
  assign load      = accept & (cmd_len != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      cur_bit_q  <= 1'b0;
      w_out_q    <= 1'b0;
      w_strobe_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      w_strobe_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load) begin
            cur_bit_q <= cmd_bit;
            rem_q     <= cmd_len;
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (bit_en) begin
            w_out_q    <= cur_bit_q;
            w_strobe_q <= 1'b1;
            if (!last) begin
              rem_q <= rem_q - REM_ONE;
            end else if (load) begin
              cur_bit_q <= cmd_bit;
              rem_q     <= cmd_len;
            end else begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  run_monitor #(
    .DETECT_N(DETECT_N)
  ) u_mon (
    .clk  (clk),
    .rst_n(rst_n),
    .s    (w_out_q),
    .flag (run_flag)
  );

  assign w_out    = w_out_q;
  assign w_strobe = w_strobe_q;
  assign busy     = (state_q == SEND);
  assign done     = done_q;

endmodule

// File: tb/tb_run_stream_tx.sv
// Bench for run_stream_tx: directed scenarios plus random traffic
// checked against a bit-queue reference model.
module tb_run_stream_tx;

  localparam int DN = 4;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_bit;
  logic [3:0] cmd_len;
  logic       bit_en;
  logic       w_out;
  logic       w_strobe;
  logic       busy;
  logic       done;
  logic       run_flag;

  run_stream_tx #(
    .LEN_W   (4),
    .DETECT_N(DN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_bit  (cmd_bit),
    .cmd_len  (cmd_len),
    .bit_en   (bit_en),
    .w_out    (w_out),
    .w_strobe (w_strobe),
    .busy     (busy),
    .done     (done),
    .run_flag (run_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // reference model: bits still owed on the line, plus a plain run counter
  bit q[$];
  int exp_w, exp_stb, exp_done;
  int hv, hb, cnt;

  int en_mode;
  bit tog;
  int nstb, ndone, nrdy, nflag;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic get_en();
    logic e;
    if (en_mode == 0) begin
      e = 1'b1;
    end else if (en_mode == 1) begin
      tog = ~tog;
      e = tog;
    end else begin
      e = ($urandom % 4) != 0;
    end
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    exp_w = 0;
    exp_stb = 0;
    exp_done = 0;
    hv = 0;
    hb = 0;
    cnt = 0;
  endtask

  task automatic cycle(input logic v, input logic b, input logic [3:0] l,
                       input logic en, output logic acc);
    logic rdy_exp;
    if (w_strobe === 1'b1) nstb++;
    if (done === 1'b1) ndone++;
    if (nstb >= 2 && run_flag === 1'b1) nflag++;
    chk("w_out", w_out, exp_w);
    chk("w_strobe", w_strobe, exp_stb);
    chk("done", done, exp_done);
    chk("busy", busy, q.size() > 0);
    chk("run_flag", run_flag, cnt == DN);
    cmd_valid = v;
    cmd_bit = b;
    cmd_len = l;
    bit_en = en;
    #1;
    rdy_exp = (q.size() == 0) || (q.size() == 1 && en);
    chk("cmd_ready", cmd_ready, rdy_exp);
    if (busy === 1'b1 && cmd_ready === 1'b1 && v) nrdy++;
    acc = v && rdy_exp;
    if (hv != 0 && exp_w == hb) cnt = (cnt < DN) ? cnt + 1 : DN;
    else cnt = 1;
    hb = exp_w;
    hv = 1;
    exp_stb = 0;
    exp_done = 0;
    if (q.size() > 0 && en) begin
      exp_w = q.pop_front();
      exp_stb = 1;
      if (q.size() == 0 && !(acc && l != 0)) exp_done = 1;
    end
    if (acc && l != 0) begin
      for (int i = 0; i < int'(l); i++) q.push_back(b);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    bit_en = 1'b0;
    #1;
    model_reset();
    chk("rst_w_out", w_out, 0);
    chk("rst_strobe", w_strobe, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flag", run_flag, 0);
    chk("rst_ready", cmd_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_cmd(input logic b, input logic [3:0] l);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) cycle(1'b1, b, l, get_en(), acc);
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0, get_en(), acc);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 200 && q.size() > 0; i++)
      cycle(1'b0, 1'b0, 4'd0, get_en(), acc);
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
  endtask

  task automatic clr_cnt();
    nstb = 0;
    ndone = 0;
    nrdy = 0;
    nflag = 0;
  endtask

  initial begin
    logic acc;
    n_chk = 0;
    n_fail = 0;
    en_mode = 0;
    tog = 1'b0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_bit = 1'b0;
    cmd_len = 4'd0;
    bit_en = 1'b0;
    clr_cnt();
    model_reset();
    @(negedge clk);
    do_reset();

    // held 0 after reset: flag on the 4th edge
    idle(3);
    chk("flag_pre4", run_flag, 0);
    idle(1);
    chk("flag_at4", run_flag, 1);
    idle(2);

    // back-to-back (1,3),(1,2)
    clr_cnt();
    push_cmd(1'b1, 4'd3);
    push_cmd(1'b1, 4'd2);
    drain();
    idle(2);
    chk("b2b_strobes", nstb, 5);
    chk("b2b_done", ndone, 1);
    chk("b2b_ready_in_send", nrdy, 1);

    // 0011 00: no run long enough
    clr_cnt();
    push_cmd(1'b0, 4'd2);
    push_cmd(1'b1, 4'd2);
    push_cmd(1'b0, 4'd2);
    drain();
    chk("pat_flag_cycles", nflag, 0);
    idle(6);

    // toggled pacing stretches the level
    clr_cnt();
    en_mode = 1;
    tog = 1'b0;
    push_cmd(1'b1, 4'd5);
    drain();
    idle(2);
    chk("tog_strobes", nstb, 5);
    chk("tog_done", ndone, 1);
    en_mode = 0;

    // empty commands
    clr_cnt();
    push_cmd(1'b1, 4'd0);
    idle(2);
    chk("len0_idle_strobes", nstb, 0);
    chk("len0_idle_done", ndone, 0);
    push_cmd(1'b1, 4'd3);
    push_cmd(1'b0, 4'd0);
    drain();
    idle(2);
    chk("len0_end_strobes", nstb, 3);
    chk("len0_end_done", ndone, 1);
    chk("len0_end_busy", busy, 0);

    // reset during a long run
    push_cmd(1'b1, 4'd15);
    idle(2);
    do_reset();
    clr_cnt();
    push_cmd(1'b0, 4'd2);
    drain();
    idle(2);
    chk("post_rst_strobes", nstb, 2);
    chk("post_rst_done", ndone, 1);

    // random traffic
    en_mode = 2;
    for (int i = 0; i < 600; i++) begin
      if ($urandom % 250 == 0) begin
        do_reset();
      end else begin
        logic [3:0] l;
        l = ($urandom % 5 == 0) ? 4'd0 : 4'($urandom);
        cycle(($urandom % 2) == 1, ($urandom % 2) == 1, l, get_en(), acc);
      end
    end
    drain();
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
